// File: rtl/logic_counter_mod_updown.sv
// logic_counter_mod_updown
//   Parametrised synchronous presettable counter (74HC160/161/162/163/190/191 style).
//   Generic width, programmable modulus, up/down direction, synchronous clear,
//   synchronous parallel load and ENT-gated ripple carry/borrow for cascading.
//   Optional feature macro: LOGIC_CNT_AUTORELOAD_EN adds a reload register that
//   replaces the wrap value when counting past the terminal count.
module logic_counter_mod_updown #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CK,
  input  logic             nCLR,
  input  logic             nSCLR,
  input  logic             nLOAD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] COUNTER,
  output logic             CO
);

  // Elaboration-time guard on the parameter ranges
  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
    $error("logic_counter_mod_updown: WIDTH=%0d outside 1..16", WIDTH);
  end
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("logic_counter_mod_updown: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end

  // Last value of the count cycle, zero and one at counter width
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_down;
  logic             terminal;

`ifdef LOGIC_CNT_AUTORELOAD_EN
  logic [WIDTH-1:0] rld;

  // Reload register: cleared by the async clear, captures DATAIN on every load edge
  always_ff @(posedge CK or negedge nCLR) begin
    if (!nCLR) begin
      rld <= ZERO;
    end else if (!nLOAD) begin
      rld <= DATAIN;
    end else begin
      rld <= rld;
    end
  end

  // Wrapping past terminal restarts from the reload value in either direction
  always_comb begin
    wrap_up   = rld;
    wrap_down = rld;
  end
`else
  // Wrapping past terminal restarts the natural cycle
  always_comb begin
    wrap_up   = ZERO;
    wrap_down = TOP;
  end
`endif

  // Terminal detect and ripple carry/borrow; follows UP and ENT without waiting for a clock
  always_comb begin
    terminal = 1'b0;
    if (UP) begin
      terminal = (COUNTER >= TOP);
    end else begin
      terminal = (COUNTER == ZERO);
    end
    CO = ENT & terminal;
  end

  // Next-count selection: sync clear > load > count > hold
  always_comb begin
    next_count = COUNTER;
    if (!nSCLR) begin
      next_count = ZERO;
    end else if (!nLOAD) begin
      // Loaded verbatim, even when outside the count cycle
      next_count = DATAIN;
    end else if (ENP && ENT) begin
      if (UP) begin
        if (COUNTER >= TOP) begin
          next_count = wrap_up;
        end else begin
          next_count = COUNTER + ONE;
        end
      end else begin
        if (COUNTER == ZERO) begin
          next_count = wrap_down;
        end else if (COUNTER > TOP) begin
          // Out-of-range value re-enters the cycle at its top
          next_count = TOP;
        end else begin
          next_count = COUNTER - ONE;
        end
      end
    end else begin
      next_count = COUNTER;
    end
  end

  // Count register with asynchronous active-low clear
  always_ff @(posedge CK or negedge nCLR) begin
    if (!nCLR) begin
      COUNTER <= ZERO;
    end else begin
      COUNTER <= next_count;
    end
  end

endmodule

// File: tb/tb_logic_counter_mod_updown.sv
// Scoreboard bench for logic_counter_mod_updown (WIDTH=4, MODULUS=10).
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
// Also exercises a two-stage cascade. Honours LOGIC_CNT_AUTORELOAD_EN.
module tb_logic_counter_mod_updown;

  typedef struct {
    bit         tag;   // 0: single stage, 1: cascade pair
    logic [7:0] cnt;
    logic       co;
    string      nm;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       CK = 1'b0;
  logic       nCLR, nSCLR, nLOAD, ENP, ENT, UP;
  logic [3:0] DATAIN;
  logic [3:0] COUNTER;
  logic       CO;

  logic       c_nclr, c_enp, c_ent, c_up;
  logic [3:0] c_lo, c_hi;
  logic       c_lo_co, c_hi_co;

  always #5 CK = ~CK;

  logic_counter_mod_updown #(.WIDTH(4), .MODULUS(10)) dut (
    .CK(CK), .nCLR(nCLR), .nSCLR(nSCLR), .nLOAD(nLOAD), .ENP(ENP), .ENT(ENT),
    .UP(UP), .DATAIN(DATAIN), .COUNTER(COUNTER), .CO(CO)
  );

  logic_counter_mod_updown #(.WIDTH(4), .MODULUS(10)) stage_lo (
    .CK(CK), .nCLR(c_nclr), .nSCLR(1'b1), .nLOAD(1'b1), .ENP(c_enp), .ENT(c_ent),
    .UP(c_up), .DATAIN(4'd0), .COUNTER(c_lo), .CO(c_lo_co)
  );

  logic_counter_mod_updown #(.WIDTH(4), .MODULUS(10)) stage_hi (
    .CK(CK), .nCLR(c_nclr), .nSCLR(1'b1), .nLOAD(1'b1), .ENP(c_enp), .ENT(c_lo_co),
    .UP(c_up), .DATAIN(4'd0), .COUNTER(c_hi), .CO(c_hi_co)
  );

  // Monitor: pops expectations on each falling edge or on an explicit mid-cycle check
  initial begin
    exp_t       e;
    logic [7:0] act_cnt;
    logic       act_co;
    forever begin
      @(negedge CK or chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.tag) begin
          act_cnt = {c_hi, c_lo};
          act_co  = c_hi_co;
        end else begin
          act_cnt = {4'd0, COUNTER};
          act_co  = CO;
        end
        n_cmp++;
        if ((act_cnt !== e.cnt) || (act_co !== e.co)) begin
          n_bad++;
          $display("FAIL %s: got cnt=0x%0h co=%0b, expected cnt=0x%0h co=%0b",
                   e.nm, act_cnt, act_co, e.cnt, e.co);
        end
      end
    end
  end

  // One clock of single-stage stimulus with its expected post-edge state
  task automatic cyc(input logic nclr, input logic nsclr, input logic nload,
                     input logic enp, input logic ent, input logic up,
                     input logic [3:0] din, input logic [7:0] ec, input logic eco,
                     input string nm);
    nCLR = nclr; nSCLR = nsclr; nLOAD = nload;
    ENP = enp; ENT = ent; UP = up; DATAIN = din;
    @(posedge CK);
    #1;
    q.push_back('{1'b0, ec, eco, nm});
    @(negedge CK);
    #1;
  endtask

  // One clock of cascade stimulus with its expected {hi,lo} and top-stage CO
  task automatic cyc_c(input logic nclr, input logic enp, input logic ent,
                       input logic [7:0] ec, input logic eco, input string nm);
    c_nclr = nclr; c_enp = enp; c_ent = ent; c_up = 1'b1;
    @(posedge CK);
    #1;
    q.push_back('{1'b1, ec, eco, nm});
    @(negedge CK);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    logic [3:0] v;
    nCLR = 1'b0; nSCLR = 1'b1; nLOAD = 1'b1; ENP = 1'b0; ENT = 1'b0; UP = 1'b1;
    DATAIN = 4'd0;
    c_nclr = 1'b0; c_enp = 1'b0; c_ent = 1'b0; c_up = 1'b1;

    // Reset state; CO in reset only when counting down with ENT=1
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, "reset_up");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, "reset_dn_co");

    // Up count 12 edges from 0: 1..9,0,1,2 with CO only at 9
    for (int i = 1; i <= 12; i++) begin
      v = 4'(i % 10);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, {4'd0, v}, (v == 4'd9), "count_up");
    end

    // Async clear mid-cycle at 7
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 8'd7, 1'b0, "load_7");
    nCLR = 1'b0;
    #1;
    q.push_back('{1'b0, 8'd0, 1'b0, "async_clear"});
    -> chk_ev;
    #1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, "clear_hold_a");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, "clear_hold_b");

    // Prime reload with 9, then sync clear to 0 so both build variants agree on down wrap
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 8'd9, 1'b0, "load_9");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, "sclr_to_0");

    // Down count from 0: 9,8,...,0 with CO only at 0
    for (int i = 1; i <= 10; i++) begin
      v = 4'((10 - i) % 10);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, {4'd0, v}, (v == 4'd0), "count_dn");
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, "dn_zero_ent0");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, "dn_zero_enp0");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd9, 1'b0, "dn_wrap");

    // Sync clear beats load; out-of-range load then resolve within one count
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 8'd0, 1'b0, "sclr_over_load");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 8'd13, 1'b1, "load_13");
`ifdef LOGIC_CNT_AUTORELOAD_EN
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd13, 1'b1, "oor_up_reload");
`else
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, "oor_up_wrap");
`endif
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd12, 8'd12, 1'b0, "load_12_dn");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd9, 1'b0, "oor_dn_top");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'd9, 1'b1, "dir_change_co");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 8'd9, 1'b0, "ent0_hold");

`ifdef LOGIC_CNT_AUTORELOAD_EN
    // Programmable divider: reload 6 instead of wrapping, retained across sync clear
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 8'd6, 1'b0, "rld_load_6");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd7, 1'b0, "rld_7");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd8, 1'b0, "rld_8");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd9, 1'b1, "rld_9");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd6, 1'b0, "rld_wrap_6");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd7, 1'b0, "rld_7b");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, "rld_sclr");
    for (int i = 1; i <= 9; i++) begin
      v = 4'(i);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, {4'd0, v}, (v == 4'd9), "rld_run");
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd6, 1'b0, "rld_kept_6");
`endif

    // Cascade: two decade stages, reset then 99 edges 01..99
    cyc_c(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "casc_reset");
    for (int i = 1; i <= 99; i++) begin
      cyc_c(1'b1, 1'b1, 1'b1, {4'(i / 10), 4'(i % 10)}, (i == 99), "casc_count");
    end
    // Both stages held by ENP=0; CO still follows ENT & terminal
    cyc_c(1'b1, 1'b0, 1'b1, 8'h99, 1'b1, "casc_hold_ent1");
    cyc_c(1'b1, 1'b0, 1'b0, 8'h99, 1'b0, "casc_hold_ent0");
    // 100th counting edge rolls the pair over to 00
    cyc_c(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, "casc_rollover");

    @(negedge CK);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
